// File: rtl/sub_n1024_cc32_if.sv
// Limb stream bundle for the limb-serial subtractor: operand limbs in,
// difference limbs plus end-of-operation compare flags out.
interface sub_n1024_cc32_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         out_last;
  logic         borrow_out;
  logic         eq_out;
  logic         flags_valid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, out_last, borrow_out, eq_out, flags_valid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, out_last, borrow_out, eq_out, flags_valid
  );
endinterface

// File: rtl/sub_n1024_cc32.sv
// Limb-serial N-bit subtractor c = a - b, LSB limb first, with a one-deep
// output register, limb counter and end-of-operation a<b / a==b flags.
module sub_n1024_cc32 #(
  parameter int unsigned N  = 1024,
  parameter int unsigned W  = 32,
  parameter int unsigned CC = N / W
) (
  input logic              clk,
  input logic              rst,
  sub_n1024_cc32_if.slave  bus
);
  localparam int unsigned KW = (CC > 1) ? $clog2(CC) : 1;

  logic [KW-1:0] k;
  logic          brw;
  logic          eqa;
  logic [W-1:0]  c_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          borrow_out_q;
  logic          eq_out_q;
  logic          flags_valid_q;

  logic          acc;
  logic          drain;
  logic          first;
  logic          last;
  logic          bin;
  logic          eq_next;
  logic [W:0]    diff;

  assign bus.in_ready    = !out_valid_q | bus.out_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.c           = c_q;
  assign bus.out_last    = out_last_q;
  assign bus.borrow_out  = borrow_out_q;
  assign bus.eq_out      = eq_out_q;
  assign bus.flags_valid = flags_valid_q;

  always_comb begin
    acc   = bus.in_valid & bus.in_ready;
    drain = out_valid_q & bus.out_ready;
    first = (k == '0);
    last  = (k == KW'(CC - 1));
    bin   = first ? 1'b0 : brw;
    // W+1-bit difference: the top bit is set exactly when a < b + bin
    diff    = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bin};
    eq_next = (first ? 1'b1 : eqa) & (bus.a == bus.b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k             <= '0;
      brw           <= 1'b0;
      eqa           <= 1'b1;
      c_q           <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      borrow_out_q  <= 1'b0;
      eq_out_q      <= 1'b0;
      flags_valid_q <= 1'b0;
    end else if (acc) begin
      c_q         <= diff[W-1:0];
      brw         <= diff[W];
      eqa         <= eq_next;
      out_valid_q <= 1'b1;
      out_last_q  <= last;
      k           <= last ? '0 : k + KW'(1);
      if (last) begin
        borrow_out_q  <= diff[W];
        eq_out_q      <= eq_next;
        flags_valid_q <= 1'b1;
      end else if (first) begin
        flags_valid_q <= 1'b0;
      end
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sub_n1024_cc32.sv
// Table-driven bench for sub_n1024_cc32: directed and random operands checked
// against full-width arithmetic, with backpressure, input gaps and mid-op reset.
module tb_sub_n1024_cc32;
  localparam int unsigned N  = 1024;
  localparam int unsigned W  = 32;
  localparam int unsigned CC = N / W;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic         bo;
    logic         eq;
    int           stall_at;
    bit           rnd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  sub_n1024_cc32_if #(.W(W)) bus ();

  sub_n1024_cc32 #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int i = 0; i < int'(CC); i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input int stall_at, input bit rnd);
    vec_t v;
    logic [N:0] d;
    d          = {1'b0, a} - {1'b0, b};
    v.a        = a;
    v.b        = b;
    v.c        = d[N-1:0];
    v.bo       = d[N];
    v.eq       = (a == b);
    v.stall_at = stall_at;
    v.rnd      = rnd;
    return v;
  endfunction

  function automatic vec_t directed(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [N-1:0] c, input logic bo, input logic eq);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.bo = bo; v.eq = eq; v.stall_at = -1; v.rnd = 1'b0;
    return v;
  endfunction

  // Entered and left just after a rising edge.
  task automatic run_op(input vec_t v);
    int unsigned kin, nout, cyc, stall_cnt;
    logic [W-1:0] held_c;
    logic         held_last;
    bit           hold;
    kin = 0; nout = 0; cyc = 0; stall_cnt = 0; hold = 0;
    held_c = '0; held_last = 1'b0;
    while (nout < CC && cyc < 3000) begin
      bus.in_valid = (kin < CC) && (!v.rnd || $urandom_range(0, 3) != 0);
      bus.a = (kin < CC) ? v.a[kin*W +: W] : '0;
      bus.b = (kin < CC) ? v.b[kin*W +: W] : '0;
      if (v.stall_at >= 0 && nout == unsigned'(v.stall_at) && stall_cnt < 5) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = (kin < CC);
        stall_cnt++;
      end else begin
        bus.out_ready = !v.rnd || $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      if (hold) begin
        chk("hold_out_valid", 64'(bus.out_valid), 64'(1'b1));
        chk("hold_c", 64'(bus.c), 64'(held_c));
        chk("hold_out_last", 64'(bus.out_last), 64'(held_last));
      end
      hold      = bus.out_valid && !bus.out_ready;
      held_c    = bus.c;
      held_last = bus.out_last;
      if (hold) chk("stall_in_ready", 64'(bus.in_ready), 64'(1'b0));
      if (bus.out_valid && bus.out_ready) begin
        chk("c_limb", 64'(bus.c), 64'(v.c[nout*W +: W]));
        chk("out_last", 64'(bus.out_last), 64'(nout == CC - 1));
        if (nout == CC - 1) begin
          chk("flags_valid_end", 64'(bus.flags_valid), 64'(1'b1));
          chk("borrow_out", 64'(bus.borrow_out), 64'(v.bo));
          chk("eq_out", 64'(bus.eq_out), 64'(v.eq));
        end else begin
          chk("flags_valid_mid", 64'(bus.flags_valid), 64'(1'b0));
        end
        nout++;
      end
      if (bus.in_valid && bus.in_ready) kin++;
      @(posedge clk); #1;
      cyc++;
    end
    if (nout < CC) chk("op_timeout_beats", 64'(nout), 64'(CC));
    if (v.stall_at >= 0) chk("stall_cycles", 64'(stall_cnt), 64'(5));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic [N-1:0] one, zero, ones, r, rb, top;
    vec_t         rst_op;

    one  = '0; one[0] = 1'b1;
    zero = '0;
    ones = '1;
    top  = '0; top[N-1 -: W] = '1;

    tbl.push_back(directed(one, zero, one, 1'b0, 1'b0));
    tbl.push_back(directed(zero, one, ones, 1'b1, 1'b0));
    r = rand_wide();
    r[N-1 -: W] = r[N-1 -: W] & 32'h7FFF_FFFF;
    tbl.push_back(directed(r, r, zero, 1'b0, 1'b1));
    rb = r;
    rb[N-1 -: W] = rb[N-1 -: W] + 32'd1;
    tbl.push_back(directed(r, rb, top, 1'b1, 1'b0));
    begin
      logic [N-1:0] a2, c2;
      a2 = '0; a2[W] = 1'b1;
      c2 = '0; c2[W-1:0] = '1;
      tbl.push_back(directed(a2, one, c2, 1'b0, 1'b0));
    end
    r  = rand_wide();
    rb = rand_wide();
    tbl.push_back(model(r, rb, -1, 1'b0));
    tbl.push_back(model(r, rb, 10, 1'b0));
    for (int i = 0; i < 6; i++) tbl.push_back(model(rand_wide(), rand_wide(), -1, 1'b1));
    r = rand_wide();
    rb = r;
    rb[0] = ~rb[0];
    tbl.push_back(model(r, rb, -1, 1'b1));
    tbl.push_back(model(r, r, -1, 1'b1));

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rst_c", 64'(bus.c), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(1'b0));
    chk("rst_flags_valid", 64'(bus.flags_valid), 64'(1'b0));
    chk("rst_borrow_out", 64'(bus.borrow_out), 64'(1'b0));
    chk("rst_eq_out", 64'(bus.eq_out), 64'(1'b0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);

    // Abort an a<b operation at limb 17 with an accept pending during rst.
    for (int i = 0; i < 17; i++) begin
      bus.in_valid  = 1'b1;
      bus.a         = '0;
      bus.b         = (i == 0) ? 32'd1 : 32'd0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("midrst_flags_valid", 64'(bus.flags_valid), 64'(1'b0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    @(posedge clk); #1;
    rst_op = directed(one, zero, one, 1'b0, 1'b0);
    run_op(rst_op);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sub_n1024_cc32.md
# sub_n1024_cc32

Limb-serial 1024-bit subtractor, the borrow-side counterpart of the limb-serial adder in the sum netlist family. It computes c = a − b over N bits, one W-bit limb per accepted beat, LSB limb first, keeping the borrow in a register between cycles. It adds a limb counter, a valid/ready handshake with single-stage output buffering, and end-of-operation compare flags (a<b, a==b). Garbled-circuit netlists for big-integer comparison and modular reduction use it as their subtraction and compare primitive.

## Interface
- N, 1024, operand width in bits
- W, 32, limb width in bits; N must be a multiple of W
- CC, N/W (32), limbs per operation; counter width is clog2(CC)
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a/b limb present
- in_ready  out  1  block can accept a limb this cycle
- a  in  W  minuend limb
- b  in  W  subtrahend limb
- out_valid  out  1  c holds a result limb
- out_ready  in  1  consumer takes c this cycle
- c  out  W  difference limb
- out_last  out  1  c is limb CC−1 of the operation
- borrow_out  out  1  final borrow, meaning a < b (unsigned); valid when flags_valid=1
- eq_out  out  1  a == b over all N bits; valid when flags_valid=1
- flags_valid  out  1  borrow_out and eq_out hold the result of the last completed operation

## Operation
- Accept: acc = in_valid & in_ready. Output handshake completes when out_valid & out_ready.
- in_ready = !out_valid | out_ready, combinational. This is a one-deep pipeline with no skid buffer.
- Limb index k is held in a counter. On each accept, k increments. It wraps CC−1 → 0.
- Borrow-in: bin = 0 when k==0, otherwise the borrow register. Operations never leak borrow into each other.
- On accept:
  - c ← (a − b − bin) mod 2^W
  - borrow register ← 1 iff a < b + bin, computed at W+1 bits
  - out_valid ← 1
  - out_last ← (k==CC−1)
- Equality accumulator: eqa ← (k==0 ? 1 : eqa) & (a==b).
- On accept with k==CC−1:
  - borrow_out ← final borrow
  - eq_out ← final eqa
  - flags_valid ← 1
- On accept with k==0, flags_valid ← 0. borrow_out and eq_out hold their old values until the next operation completes.
- When out_valid & out_ready and there is no accept in the same cycle, out_valid ← 0.
- Simultaneous drain and accept: the new limb replaces c and out_valid stays 1.
- While out_valid=1 and out_ready=0:
  - c, out_last, the counter and the borrow register are frozen.
  - in_ready=0, so a and b are ignored.
- in_valid may drop between limbs for any number of cycles. State is held and the operation resumes at the same k.

## Timing
- Reset values: c=0, out_valid=0, out_last=0, borrow_out=0, eq_out=0, flags_valid=0, counter=0, borrow register=0, eqa=1. in_ready=1 in the cycle after reset.
- Latency is 1 cycle from an accepted limb to that limb on c with out_valid=1.
- Throughput is 1 limb per cycle while out_ready=1. A full operation takes CC=32 accepts. The flags are valid in the same cycle that out_last=1 first appears.
- Reset mid-operation:
  - Partial results are discarded and the counter returns to 0.
  - The next accepted limb is treated as limb 0 with bin=0.
  - rst has priority over a simultaneous accept.
- No combinational path from a or b to any output. The only combinational output path is out_ready → in_ready.

## Test plan
- a=1 (limb0=0x00000001, others 0), b=0, out_ready=1 → 32 consecutive out_valid beats. c limb0=0x00000001, other limbs 0x00000000, out_last only on beat 32. borrow_out=0, eq_out=0, flags_valid=1.
- a=0, b=1 → every c limb 0xFFFFFFFF, borrow_out=1, eq_out=0.
- a=b (random 1024-bit value) → every c limb 0, borrow_out=0, eq_out=1. Repeat with only limb31 of b incremented: eq_out=0, borrow_out=1.
- Borrow across limbs: a limb1=0x00000001 (others 0), b limb0=0x00000001 (others 0) → c limb0=0xFFFFFFFF, limb1=0x00000000, rest 0, borrow_out=0.
- Backpressure: hold out_ready=0 for 5 cycles at limb 10 with in_valid=1 → in_ready=0, c/out_last stable, no limb lost or duplicated. Final results match the no-stall run.
- Pulse rst at limb 17 of an a<b operation, then run a=1, b=0 → results are as in the first scenario, with no stale borrow. flags_valid=0 after reset until the new operation completes.
